// File: rtl/char_power_ctrl.sv
// Character power-up state machine: small/big sizing, grow/shrink animation,
// post-hit invulnerability with blink, death, and mushroom bonus pulse.
module char_power_ctrl #(
  parameter int GROW_FRAMES = 4,
  parameter int INV_FRAMES  = 8
) (
  input  logic       sys_clk,
  input  logic       RST,
  input  logic       touch_g_ms,
  input  logic       touch_enemy,
  input  logic       frame_tick,
  output logic       is_big,
  output logic [9:0] char_h,
  output logic       grow_anim,
  output logic       blink,
  output logic       dead,
  output logic       score_add,
  output logic [2:0] state_dbg,
  output logic [7:0] ftmr_dbg
);

  // Touch inputs and frame_tick are single-cycle strobes with no handshake:
  // each high cycle is one event, sampled on the rising edge of sys_clk.

  localparam logic [2:0] S_SMALL     = 3'd0;
  localparam logic [2:0] S_GROWING   = 3'd1;
  localparam logic [2:0] S_BIG       = 3'd2;
  localparam logic [2:0] S_SHRINKING = 3'd3;
  localparam logic [2:0] S_INVULN    = 3'd4;
  localparam logic [2:0] S_DEAD      = 3'd5;

  localparam logic [7:0] GROW_LAST = 8'(GROW_FRAMES - 1);
  localparam logic [7:0] INV_LAST  = 8'(INV_FRAMES - 1);

  logic [2:0] state, state_nx;
  logic [7:0] ftmr;
  logic       timed;

  assign timed = (state == S_GROWING) || (state == S_SHRINKING) ||
                 (state == S_INVULN);

  always_comb begin
    state_nx = state;
    case (state)
      S_SMALL: begin
        if (touch_g_ms)       state_nx = S_GROWING;
        else if (touch_enemy) state_nx = S_DEAD;
      end
      S_GROWING: begin
        if (frame_tick && ftmr == GROW_LAST) state_nx = S_BIG;
      end
      S_BIG: begin
        if (touch_enemy) state_nx = S_SHRINKING;
      end
      S_SHRINKING: begin
        if (frame_tick && ftmr == GROW_LAST) state_nx = S_INVULN;
      end
      S_INVULN: begin
        // A mushroom cancels invulnerability even on the expiring tick.
        if (touch_g_ms)                          state_nx = S_GROWING;
        else if (frame_tick && ftmr == INV_LAST) state_nx = S_SMALL;
      end
      S_DEAD:  state_nx = S_DEAD;
      default: state_nx = S_SMALL;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (RST) begin
      state     <= S_SMALL;
      ftmr      <= 8'd0;
      score_add <= 1'b0;
    end else begin
      state     <= state_nx;
      score_add <= (state == S_BIG) && touch_g_ms;
      if (state_nx != state)       ftmr <= 8'd0;
      else if (timed && frame_tick) ftmr <= ftmr + 8'd1;
    end
  end

  always_comb begin
    is_big    = (state == S_BIG);
    grow_anim = (state == S_GROWING) || (state == S_SHRINKING);
    dead      = (state == S_DEAD);
    blink     = (state == S_INVULN) && ftmr[1];
    // Size flickers between small and big while animating.
    if (is_big || (grow_anim && ftmr[0])) char_h = 10'd24;
    else                                  char_h = 10'd12;
  end

  assign state_dbg = state;
  assign ftmr_dbg  = ftmr;

endmodule

// File: doc/char_power_ctrl.md
CHAR_POWER_CTRL -- requirements
Module: char_power_ctrl

Interface
REQ-001 Parameter GROW_FRAMES, default 4, frame ticks spent in the GROWING or SHRINKING animation (legal 1..255).
REQ-002 Parameter INV_FRAMES, default 8, frame ticks of post-hit invulnerability (legal 1..255).
REQ-003 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset; synchronous, active-high.
REQ-005 touch_g_ms  in  1  one-cycle mushroom-contact pulse from the item block.
REQ-006 touch_enemy  in  1  one-cycle enemy-contact pulse.
REQ-007 frame_tick  in  1  one-cycle strobe per video frame; all timers advance only on it.
REQ-008 is_big  out  1  high only in state BIG.
REQ-009 char_h  out  10  character hitbox height in pixels, 12 or 24.
REQ-010 grow_anim  out  1  high in GROWING or SHRINKING.
REQ-011 blink  out  1  sprite-hide strobe during invulnerability.
REQ-012 dead  out  1  high in DEAD.
REQ-013 score_add  out  1  one-cycle bonus pulse.

Function
REQ-014 States: SMALL, GROWING, BIG, SHRINKING, INVULN, DEAD; 8-bit frame timer ftmr.
REQ-015 Every state entry clears ftmr to 0 in the same edge as the transition.
REQ-016 In GROWING, SHRINKING, INVULN: ftmr increments by 1 on each frame_tick; otherwise it holds.
REQ-017 SMALL: touch_g_ms -> GROWING; else touch_enemy -> DEAD; simultaneous pulses -> GROWING (mushroom wins).
REQ-018 GROWING: frame_tick with ftmr == GROW_FRAMES-1 -> BIG; touch_g_ms and touch_enemy ignored.
REQ-019 BIG: touch_enemy -> SHRINKING; touch_g_ms -> score_add high next cycle for exactly 1 cycle; both together -> SHRINKING and score_add pulse.
REQ-020 SHRINKING: frame_tick with ftmr == GROW_FRAMES-1 -> INVULN; all touch inputs ignored.
REQ-021 INVULN: frame_tick with ftmr == INV_FRAMES-1 -> SMALL; touch_enemy ignored; touch_g_ms -> GROWING (cancels invulnerability), taking priority over expiry in the same cycle.
REQ-022 DEAD: absorbing; all inputs ignored until RST.
REQ-023 score_add is registered; asserted only per REQ-019; never asserted in other states.
REQ-024 char_h: 24 in BIG; 12 in SMALL, INVULN, DEAD; in GROWING/SHRINKING 24 when ftmr[0]=1 else 12 (size flicker).
REQ-025 blink = ftmr[1] in INVULN, else 0.
REQ-026 All outputs are functions of registered state/ftmr/score_add only; no combinational input-to-output path.
REQ-027 Touch pulses held high for multiple cycles are treated as one event per cycle; state-based rules above make repeats harmless except REQ-019 score_add, which pulses once per cycle of touch_g_ms in BIG.

Reset
REQ-028 RST high at a sys_clk edge: state=SMALL, ftmr=0, score_add=0; hence is_big=0, char_h=12, grow_anim=0, blink=0, dead=0.
REQ-029 RST overrides all inputs, including mid-animation and in DEAD; first post-reset edge with RST low evaluates SMALL rules.

Verification (GROW_FRAMES=4, INV_FRAMES=8)
REQ-030 Reset, pulse touch_g_ms -> GROWING next edge; char_h sequence per tick 12,24,12,24; after 4th frame_tick is_big=1, char_h=24, grow_anim=0.
REQ-031 In BIG pulse touch_g_ms twice (separate cycles) -> two single-cycle score_add pulses, state stays BIG.
REQ-032 In BIG pulse touch_enemy -> SHRINKING 4 ticks, INVULN 8 ticks with blink pattern 0,0,1,1,0,0,1,1, touch_enemy during INVULN ignored, then SMALL char_h=12.
REQ-033 In SMALL pulse touch_enemy -> dead=1; further touch_g_ms ignored; RST -> dead=0, SMALL.
REQ-034 Simultaneous touch_g_ms+touch_enemy in SMALL -> GROWING; in BIG -> SHRINKING plus one score_add pulse.
REQ-035 In INVULN, touch_g_ms on the expiring frame_tick -> GROWING; RST asserted mid-GROWING -> SMALL, ftmr=0 next edge.
